// File: rtl/uart_rx_ctrl.sv
// MiniUART receive sequencer: baud-tick divider for rx_unit, one-shot capture/ack FSM,
// and a first-word-fall-through byte FIFO with sticky overrun and interrupt.
module uart_rx_ctrl #(
  parameter int DIV_W      = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_en,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic                  cfg_irq_en,
  output logic                  rx_en,
  input  logic [7:0]            rx_data,
  input  logic                  rx_rs,
  output logic                  rx_over_read,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   fifo_cnt,
  output logic                  ovr,
  input  logic                  ovr_clr,
  output logic                  irq
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_CLR} state_e;

  // ---------------- sample-tick divider ----------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             rx_en_q, rx_en_d;

  // >= rather than == so a shrinking cfg_div ticks at once instead of wrapping
  always_comb begin
    div_cnt_d = '0;
    rx_en_d   = 1'b0;
    if (cfg_en) begin
      if (div_cnt_q >= cfg_div) rx_en_d = 1'b1;
      else                      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      rx_en_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      rx_en_q   <= rx_en_d;
    end
  end

  // ---------------- capture FSM ----------------
  state_e state_q, state_d;
  logic   cap;

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_rs) begin
          cap     = 1'b1;
          state_d = ACK;
        end
      end
      ACK:      state_d = WAIT_CLR;
      WAIT_CLR: if (!rx_rs) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FIFO ----------------
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic [7:0]            head_q, head_d;
  logic                  ovr_q, ovr_d;
  logic                  full, push, pop, drop;

  assign full = (cnt_q == DEPTH_CNT);
  assign pop  = rd_en & (cnt_q != '0);
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Registered head: the byte being written this edge bypasses the array
    head_d = head_q;
    if (cnt_d != '0)
      head_d = (push && (rptr_d == wptr_q)) ? rx_data : mem_q[rptr_d];
    ovr_d = drop | (ovr_q & ~ovr_clr);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      ovr_q  <= ovr_d;
    end
  end

  assign rx_en        = rx_en_q;
  assign rx_over_read = (state_q == ACK);
  assign rd_data      = head_q;
  assign rd_valid     = (cnt_q != '0);
  assign fifo_cnt     = cnt_q;
  assign ovr          = ovr_q;
  assign irq          = cfg_irq_en & (rd_valid | ovr_q);

endmodule
